// File: rtl/ps2_mouse_rx.sv
// Receive-only PS/2 mouse front end: filters the raw lines, deframes bytes, assembles packets, tracks clamped position and buttons.
// Optional 4-byte wheel packets and the wheel port are enabled with `define MOUSE_WHEEL_EN.
module ps2_mouse_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 20000,
  parameter int X_MAX       = 1023,
  parameter int Y_MAX       = 767,
  parameter int X_INIT      = 512,
  parameter int Y_INIT      = 384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        mouse_left,
  output logic        mouse_right,
  output logic        packet_valid,
`ifdef MOUSE_WHEEL_EN
  output logic [3:0]  wheel,
`endif
  output logic        frame_err
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic signed [13:0] L_XMAX = 14'(X_MAX);
  localparam logic signed [13:0] L_YMAX = 14'(Y_MAX);

  typedef enum logic [1:0] {RX_IDLE, RX_BITS, RX_CHECK} rx_state_t;
  typedef enum logic [2:0] {
    PK_B0, PK_B1, PK_B2,
`ifdef MOUSE_WHEEL_EN
    PK_B3,
`endif
    PK_APPLY
  } pk_state_t;

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_clk_filt;
  logic [FW-1:0] r_filt_cnt;
  logic          w_fall;

  rx_state_t     r_rx_state, w_rx_next;
  logic [3:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par, r_stop;
  logic [TW-1:0] r_idle_cnt;
  logic          w_timeout, w_frame_ok, w_byte_vld, w_err;
  logic          r_frame_err;

  pk_state_t     r_pk_state, w_pk_next;
  logic          r_b0_left, r_b0_right, r_b0_xs, r_b0_ys, r_b0_xo, r_b0_yo;
  logic [7:0]    r_b1, r_b2;
  logic          w_apply;

  logic signed [13:0] w_dx, w_dy, w_x_sum, w_y_sum;
  logic [11:0]   w_x_clamp, w_y_clamp;
  logic [11:0]   r_xpos, r_ypos;
  logic          r_left, r_right, r_pkt_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_filt <= 1'b1;
      r_filt_cnt <= '0;
    end else if (r_clk_s2 == r_clk_filt) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
      r_clk_filt <= r_clk_s2;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end

  assign w_fall = r_clk_filt && !r_clk_s2 && (r_filt_cnt == FW'(FILTER_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rx_state <= RX_IDLE;
    else     r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (w_fall && !r_dat_s2) w_rx_next = RX_BITS;
      RX_BITS: begin
        if (w_timeout)                          w_rx_next = RX_IDLE;
        else if (w_fall && r_bit_cnt == 4'd9)   w_rx_next = RX_CHECK;
      end
      RX_CHECK: w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    w_timeout  = (r_rx_state == RX_BITS) && !w_fall && (r_idle_cnt == TW'(TIMEOUT_CYC - 1));
    w_frame_ok = (^{r_shift, r_par}) && r_stop;
    w_byte_vld = (r_rx_state == RX_CHECK) && w_frame_ok;
    w_err      = ((r_rx_state == RX_CHECK) && !w_frame_ok) || w_timeout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_stop      <= 1'b0;
      r_idle_cnt  <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_err;
      if (r_rx_state != RX_BITS || w_fall) r_idle_cnt <= '0;
      else                                 r_idle_cnt <= r_idle_cnt + 1'b1;
      if (r_rx_state == RX_IDLE) begin
        r_bit_cnt <= '0;
      end else if (r_rx_state == RX_BITS && w_fall) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
        if (r_bit_cnt < 4'd8)       r_shift <= {r_dat_s2, r_shift[7:1]};
        else if (r_bit_cnt == 4'd8) r_par   <= r_dat_s2;
        else                        r_stop  <= r_dat_s2;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pk_state <= PK_B0;
    else     r_pk_state <= w_pk_next;
  end

  always_comb begin
    w_pk_next = r_pk_state;
    case (r_pk_state)
      PK_B0: if (w_byte_vld && r_shift[3]) w_pk_next = PK_B1;
      PK_B1: begin
        if (w_err)           w_pk_next = PK_B0;
        else if (w_byte_vld) w_pk_next = PK_B2;
      end
      PK_B2: begin
        if (w_err)           w_pk_next = PK_B0;
`ifdef MOUSE_WHEEL_EN
        else if (w_byte_vld) w_pk_next = PK_B3;
      end
      PK_B3: begin
        if (w_err)           w_pk_next = PK_B0;
`endif
        else if (w_byte_vld) w_pk_next = PK_APPLY;
      end
      PK_APPLY: w_pk_next = PK_B0;
      default:  w_pk_next = PK_B0;
    endcase
  end

  always_comb begin
    w_apply = (r_pk_state == PK_APPLY);
  end

`ifdef MOUSE_WHEEL_EN
  logic [3:0] r_b3, r_wheel;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b0_left  <= 1'b0;
      r_b0_right <= 1'b0;
      r_b0_xs    <= 1'b0;
      r_b0_ys    <= 1'b0;
      r_b0_xo    <= 1'b0;
      r_b0_yo    <= 1'b0;
      r_b1       <= '0;
      r_b2       <= '0;
`ifdef MOUSE_WHEEL_EN
      r_b3       <= '0;
`endif
    end else if (w_byte_vld) begin
      case (r_pk_state)
        PK_B0: begin
          r_b0_left  <= r_shift[0];
          r_b0_right <= r_shift[1];
          r_b0_xs    <= r_shift[4];
          r_b0_ys    <= r_shift[5];
          r_b0_xo    <= r_shift[6];
          r_b0_yo    <= r_shift[7];
        end
        PK_B1:   r_b1 <= r_shift;
        PK_B2:   r_b2 <= r_shift;
`ifdef MOUSE_WHEEL_EN
        PK_B3:   r_b3 <= r_shift[3:0];
`endif
        default: ;
      endcase
    end
  end

  // Deltas are 9-bit two's complement; +Y is up, screen Y grows downward.
  always_comb begin
    w_dx    = r_b0_xo ? 14'sd0 : {{5{r_b0_xs}}, r_b0_xs, r_b1};
    w_dy    = r_b0_yo ? 14'sd0 : {{5{r_b0_ys}}, r_b0_ys, r_b2};
    w_x_sum = $signed({2'b00, r_xpos}) + w_dx;
    w_y_sum = $signed({2'b00, r_ypos}) - w_dy;
    if (w_x_sum < 0)            w_x_clamp = 12'd0;
    else if (w_x_sum > L_XMAX)  w_x_clamp = 12'(X_MAX);
    else                        w_x_clamp = w_x_sum[11:0];
    if (w_y_sum < 0)            w_y_clamp = 12'd0;
    else if (w_y_sum > L_YMAX)  w_y_clamp = 12'(Y_MAX);
    else                        w_y_clamp = w_y_sum[11:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xpos    <= 12'(X_INIT);
      r_ypos    <= 12'(Y_INIT);
      r_left    <= 1'b0;
      r_right   <= 1'b0;
      r_pkt_vld <= 1'b0;
`ifdef MOUSE_WHEEL_EN
      r_wheel   <= '0;
`endif
    end else begin
      r_pkt_vld <= w_apply;
`ifdef MOUSE_WHEEL_EN
      r_wheel   <= w_apply ? r_b3 : 4'd0;
`endif
      if (w_apply) begin
        r_xpos  <= w_x_clamp;
        r_ypos  <= w_y_clamp;
        r_left  <= r_b0_left;
        r_right <= r_b0_right;
      end
    end
  end

  assign xpos         = r_xpos;
  assign ypos         = r_ypos;
  assign mouse_left   = r_left;
  assign mouse_right  = r_right;
  assign packet_valid = r_pkt_vld;
  assign frame_err    = r_frame_err;
`ifdef MOUSE_WHEEL_EN
  assign wheel        = r_wheel;
`endif

endmodule
